// File: rtl/ntt_job_scheduler.sv
// Round-robin job scheduler sharing one NTT pipeline among several requesters.
// Sequences input loads, tracks owners in a tag FIFO and labels returned bursts.
module ntt_job_scheduler #(
    parameter int NUM_REQ        = 2,
    parameter int BEATS_PER_POLY = 4,
    parameter int MAX_INFLIGHT   = 4,
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int BW  = (BEATS_PER_POLY > 1) ? $clog2(BEATS_PER_POLY) : 1,
    localparam int CW  = $clog2(MAX_INFLIGHT + 1),
    localparam int PW  = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [BW-1:0]      in_beat_idx,
    output logic               ntt_in_start,
    input  logic               ntt_out_start,
    output logic               out_valid,
    output logic [IDW-1:0]     out_id,
    output logic [BW-1:0]      out_beat_idx,
    output logic               out_last,
    output logic [CW-1:0]      inflight,
    output logic               err
);

    typedef enum logic {I_IDLE = 1'b0, I_LOAD = 1'b1} in_state_t;
    typedef enum logic {O_IDLE = 1'b0, O_EMIT = 1'b1} out_state_t;

    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS_PER_POLY - 1);

    in_state_t          in_state, in_state_n;
    logic [BW-1:0]      in_cnt, in_cnt_n;
    logic [NUM_REQ-1:0] grant_q, grant_n;
    logic               start_q, start_n;
    logic [IDW-1:0]     rr_ptr, rr_ptr_n;

    out_state_t         out_state, out_state_n;
    logic [BW-1:0]      out_cnt, out_cnt_n;
    logic [IDW-1:0]     out_id_q, out_id_n;
    logic               err_q;

    logic [IDW-1:0]     tag_mem [MAX_INFLIGHT];
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      count;
    logic [IDW-1:0]     fifo_head;
    logic               fifo_empty;

    logic [NUM_REQ-1:0] arb_req;
    logic [IDW-1:0]     arb_idx;
    logic [IDW-1:0]     arb_winner;
    logic               arb_found;
    logic               decide, room, push_fire, pop_fire, err_hit;

    assign fifo_empty = (count == '0);
    assign fifo_head  = tag_mem[rd_ptr];
    assign pop_fire   = ntt_out_start && (out_state == O_IDLE) && !fifo_empty;
    assign err_hit    = ntt_out_start && ((out_state == O_EMIT) || fifo_empty);
    // A pop in the same cycle frees a slot, so a full FIFO can still admit a job.
    assign room       = (count < CW'(MAX_INFLIGHT)) || pop_fire;
    assign decide     = (in_state == I_IDLE) || (in_cnt == LAST_BEAT);
    assign arb_req    = (in_state == I_IDLE) ? req : (req & ~grant_q);

    always_comb begin
        arb_found  = 1'b0;
        arb_winner = '0;
        arb_idx    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            arb_idx = IDW'((int'(rr_ptr) + i) % NUM_REQ);
            if (!arb_found && arb_req[arb_idx]) begin
                arb_found  = 1'b1;
                arb_winner = arb_idx;
            end
        end
    end

    always_comb begin
        in_state_n = in_state;
        in_cnt_n   = in_cnt;
        grant_n    = grant_q;
        start_n    = 1'b0;
        rr_ptr_n   = rr_ptr;
        push_fire  = 1'b0;
        if (decide && arb_found && room) begin
            in_state_n = I_LOAD;
            in_cnt_n   = '0;
            grant_n    = NUM_REQ'(1) << arb_winner;
            start_n    = 1'b1;
            rr_ptr_n   = arb_winner;
            push_fire  = 1'b1;
        end else if (in_state == I_LOAD) begin
            if (in_cnt == LAST_BEAT) begin
                in_state_n = I_IDLE;
                in_cnt_n   = '0;
                grant_n    = '0;
            end else begin
                in_cnt_n = in_cnt + BW'(1);
            end
        end
    end

    always_comb begin
        out_state_n = out_state;
        out_cnt_n   = out_cnt;
        out_id_n    = out_id_q;
        case (out_state)
            O_IDLE: begin
                // Beat 0 is emitted combinationally; the register carries beats 1..last.
                if (pop_fire && (BEATS_PER_POLY > 1)) begin
                    out_state_n = O_EMIT;
                    out_cnt_n   = BW'(1);
                    out_id_n    = fifo_head;
                end
            end
            O_EMIT: begin
                if (out_cnt == LAST_BEAT) begin
                    out_state_n = O_IDLE;
                    out_cnt_n   = '0;
                end else begin
                    out_cnt_n = out_cnt + BW'(1);
                end
            end
            default: out_state_n = O_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_state  <= I_IDLE;
            in_cnt    <= '0;
            grant_q   <= '0;
            start_q   <= 1'b0;
            rr_ptr    <= '0;
            out_state <= O_IDLE;
            out_cnt   <= '0;
            out_id_q  <= '0;
            err_q     <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            in_state  <= in_state_n;
            in_cnt    <= in_cnt_n;
            grant_q   <= grant_n;
            start_q   <= start_n;
            rr_ptr    <= rr_ptr_n;
            out_state <= out_state_n;
            out_cnt   <= out_cnt_n;
            out_id_q  <= out_id_n;
            if (err_hit) err_q <= 1'b1;
            if (push_fire)
                wr_ptr <= (wr_ptr == PW'(MAX_INFLIGHT - 1)) ? '0 : wr_ptr + PW'(1);
            if (pop_fire)
                rd_ptr <= (rd_ptr == PW'(MAX_INFLIGHT - 1)) ? '0 : rd_ptr + PW'(1);
            case ({push_fire, pop_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) tag_mem[wr_ptr] <= arb_winner;
    end

    assign grant        = grant_q;
    assign in_beat_idx  = in_cnt;
    assign ntt_in_start = start_q;
    assign out_valid    = (out_state == O_EMIT) || pop_fire;
    assign out_id       = (out_state == O_EMIT) ? out_id_q : (pop_fire ? fifo_head : '0);
    assign out_beat_idx = (out_state == O_EMIT) ? out_cnt : '0;
    assign out_last     = out_valid && (out_beat_idx == LAST_BEAT);
    assign inflight     = count;
    assign err          = err_q;

endmodule
